bip_program_loader: RTL

- Instruction-side responder for the BIP control unit: owns program memory, fills it from a byte stream, then serves 16-bit instructions addressed by the control unit's PC.
- Holds the CPU stalled (CPU_RUN=0) until a complete, valid program is loaded.
- Sits between the UART receiver and the control unit. Drives INSTRUCTION; consumes PC.

---
 rtl/bip_program_loader_if.sv | 25 ++
 rtl/bip_program_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bip_program_loader_if.sv
// Loader bus: UART byte stream in, control-unit instruction fetch out, plus status.
// The loader connects to the slave modport; the stream source and CPU side use master.
interface bip_program_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              START_LOAD;
  logic [ADDR_W-1:0] PC;
  logic [15:0]       INSTRUCTION;
  logic              CPU_RUN;
  logic [11:0]       WORD_COUNT;
  logic              LOAD_ERR;

  modport master (
    output RX_DATA, RX_VALID, START_LOAD, PC,
    input  RX_READY, INSTRUCTION, CPU_RUN, WORD_COUNT, LOAD_ERR
  );

  modport slave (
    input  RX_DATA, RX_VALID, START_LOAD, PC,
    output RX_READY, INSTRUCTION, CPU_RUN, WORD_COUNT, LOAD_ERR
  );
endinterface

// File: rtl/bip_program_loader.sv
// BIP program loader: fills program memory from a little-endian byte stream, then serves
// instructions by PC. Optional trailing XOR checksum byte enabled by BIP_LOADER_CHECKSUM_EN.
module bip_program_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bip_program_loader_if.slave  bus
);

  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_INS_LO,
    S_INS_HI,
    S_RUN,
`ifdef BIP_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_ERROR
  } state_t;

  state_t            state_q;
  logic              rx_ready_q;
  logic              cpu_run_q;
  logic              load_err_q;
  logic [11:0]       wcnt_q;
  logic [11:0]       len_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        lo_q;
  logic [15:0]       instr_q;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic [15:0] mem [DEPTH];

  logic        xfer;
  logic        wr_en;
  logic        len_ok;
  logic        pc_in_range;
  logic        last_word;
  logic [11:0] len_d;
  logic [11:0] wcnt_d;

  assign xfer        = bus.RX_VALID && rx_ready_q;
  assign len_d       = {bus.RX_DATA[3:0], lo_q};
  assign len_ok      = (len_d != 12'd0) && ({1'b0, len_d} <= DEPTH_W);
  assign wcnt_d      = wcnt_q + 12'd1;
  assign last_word   = (wcnt_d >= len_q);
  assign pc_in_range = 32'(bus.PC) < 32'(len_q);
  assign wr_en       = xfer && !bus.START_LOAD && (state_q == S_INS_HI);

  // Program memory is deliberately not reset; stale words are hidden by the PC >= N check.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr_q] <= {bus.RX_DATA, lo_q};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_LEN_LO;
      rx_ready_q <= 1'b1;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
      wcnt_q     <= 12'd0;
      len_q      <= 12'd0;
      wr_addr_q  <= '0;
      lo_q       <= 8'd0;
      instr_q    <= 16'h0000;
`ifdef BIP_LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else if (bus.START_LOAD) begin
      // Restart wins over any byte presented in the same cycle.
      state_q    <= S_LEN_LO;
      rx_ready_q <= 1'b1;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
      wcnt_q     <= 12'd0;
      wr_addr_q  <= '0;
      instr_q    <= 16'h0000;
`ifdef BIP_LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      instr_q <= (state_q == S_RUN && pc_in_range) ? mem[bus.PC] : 16'h0000;
      if (xfer) begin
        case (state_q)
          S_LEN_LO: begin
            lo_q    <= bus.RX_DATA;
            state_q <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_ok) begin
              len_q     <= len_d;
              wcnt_q    <= 12'd0;
              wr_addr_q <= '0;
`ifdef BIP_LOADER_CHECKSUM_EN
              chk_q     <= 8'd0;
`endif
              state_q   <= S_INS_LO;
            end else begin
              load_err_q <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_ERROR;
            end
          end
          S_INS_LO: begin
            lo_q    <= bus.RX_DATA;
`ifdef BIP_LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ bus.RX_DATA;
`endif
            state_q <= S_INS_HI;
          end
          S_INS_HI: begin
            wcnt_q    <= wcnt_d;
            wr_addr_q <= wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef BIP_LOADER_CHECKSUM_EN
            chk_q     <= chk_q ^ bus.RX_DATA;
            state_q   <= last_word ? S_CHK : S_INS_LO;
`else
            if (last_word) begin
              rx_ready_q <= 1'b0;
              cpu_run_q  <= 1'b1;
              state_q    <= S_RUN;
            end else begin
              state_q    <= S_INS_LO;
            end
`endif
          end
`ifdef BIP_LOADER_CHECKSUM_EN
          S_CHK: begin
            rx_ready_q <= 1'b0;
            if (bus.RX_DATA == chk_q) begin
              cpu_run_q <= 1'b1;
              state_q   <= S_RUN;
            end else begin
              load_err_q <= 1'b1;
              state_q    <= S_ERROR;
            end
          end
`endif
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.RX_READY    = rx_ready_q;
  assign bus.CPU_RUN     = cpu_run_q;
  assign bus.LOAD_ERR    = load_err_q;
  assign bus.WORD_COUNT  = wcnt_q;
  assign bus.INSTRUCTION = instr_q;

endmodule
